avalon_bus_arbiter: RTL and testbench
=====================================

# avalon_bus_arbiter

Two-master, one-slave arbiter for the Avalon memory-mapped bus. It lets the CPU master (`m0`, the `top_level_CPU` bus port) and a secondary master (`m1`, an instruction loader or DMA) share the single `RAM` slave. Grants are round-robin and locked for one complete transfer. A per-transfer watchdog flags a slave that stalls indefinitely.

## Interface
- `TIMEOUT`, default 1023: maximum number of cycles a granted transfer may see slave `waitrequest` high before it is aborted.
- `clk` in 1: single clock; all state updates on its rising edge.
- `reset` in 1: asynchronous, active-low; forces every register and output to its reset value immediately.
- `m0_address` / `m1_address` in 32: master byte address.
- `m0_read`, `m0_write` / `m1_read`, `m1_write` in 1 each: master request strobes, held until the master sees `waitrequest` low.
- `m0_writedata` / `m1_writedata` in 32: master write data.
- `m0_byteenable` / `m1_byteenable` in 4: master byte lanes.
- `m0_waitrequest` / `m1_waitrequest` out 1: stall signal to each master.
- `m0_readdata` / `m1_readdata` out 32: read return data to each master.
- `s_address` out 32, `s_read` out 1, `s_write` out 1, `s_writedata` out 32, `s_byteenable` out 4: slave-side request.
- `s_waitrequest` in 1, `s_readdata` in 32: slave-side response.
- `grant` out 2: one-hot current owner; `2'b00` when idle.
- `timeout_err` out 1: sticky; set by any watchdog abort, cleared only by reset.

## Operation
- **Request definition.** A master requests when `mX_read | mX_write` is high.
  - If a master asserts both strobes, write takes precedence: `s_read` is forced to 0 for that transfer.
- **States.** Three states: IDLE, GNT0, GNT1.
- **IDLE.**
  - `s_read = s_write = 0`; `s_address`, `s_writedata` and `s_byteenable` are driven 0.
  - Both `mX_waitrequest = 1`.
  - Next state: if only one master requests, grant it. If both request, grant the master that is not `last_grant`. If none, stay in IDLE.
  - `last_grant` updates on entry to GNTx.
- **GNTx.**
  - Master x's address, strobes, writedata and byteenable are routed combinationally to the slave.
  - `mx_waitrequest = s_waitrequest`.
  - The other master's `waitrequest = 1`.
  - A cycle with the request high and `s_waitrequest = 0` is the completion cycle. Next state is IDLE.
- **Read data.** `m0_readdata` and `m1_readdata` both equal `s_readdata` at all times. Data is meaningful only to the granted master in its read completion cycle.
- **Request withdrawn.** If master x drops both strobes while in GNTx (protocol violation), the arbiter returns to IDLE next cycle. No error is flagged.
- **Watchdog.**
  - `wd_cnt` clears on entry to GNTx and increments each GNTx cycle with `s_waitrequest = 1`.
  - When `wd_cnt == TIMEOUT` and `s_waitrequest` is still 1:
    - drive `mx_waitrequest = 0` for that one cycle, so the master completes;
    - readdata is undefined;
    - set `timeout_err`;
    - next state is IDLE.
- **Counter width.** The counter is `$clog2(TIMEOUT+1)` bits and never wraps.

## Timing
- **Reset values:**
  - state IDLE;
  - `last_grant = m1`, so `m0` wins the first tie;
  - `wd_cnt = 0`, `grant = 0`, `timeout_err = 0`;
  - all `s_*` outputs 0;
  - both `mX_waitrequest = 1`.
- **Arbitration latency.** A request first seen in IDLE at cycle N is granted at the edge ending N. The slave sees it in cycle N+1.
  - With a zero-wait slave the master completes in N+1, a 2-cycle transfer.
  - State is back in IDLE in N+2.
- **Back-to-back.** Every transfer passes through one IDLE cycle. With continuous requests from both masters, grants alternate m0, m1, m0, …, and each master completes at best every 4 cycles.
- **Simultaneous requests in IDLE** are resolved by `last_grant` only. Request arrival order within a cycle is irrelevant.
- **Masters and waitrequest.** Masters must hold address, strobes and data stable while their `waitrequest` is 1; the arbiter does not latch them.
- **Async reset mid-transfer.** Outputs take reset values immediately with no completion to the master. On release, arbitration restarts from IDLE with `last_grant = m1`.

## Test plan
- **Reset.** Hold reset low, drive `m0_read = 1`. Then `s_read = 0`, `m0_waitrequest = 1`, `grant = 00`. Release reset: `grant = 01` after 1 edge, and `s_address` equals `m0_address`.
- **Single read.**
  - Stimulus: `m0` reads `0x15` from a zero-wait RAM holding `0x00006900`.
  - Required: `m0_waitrequest` is low exactly one cycle, in cycle 2, with `m0_readdata = 0x00006900`; `grant` returns to 00 in cycle 3.
- **Contention.**
  - Stimulus: both masters request continuously, each with a write of 69 to a distinct address.
  - Required: grant sequence is 01, 00, 10, 00, 01…; `m1` never observes `waitrequest` low while `grant = 01`.
- **Wait states.**
  - Stimulus: the slave holds `s_waitrequest` high 3 cycles on a `m1` write with `byteenable 4'b0011`.
  - Required: `m1_waitrequest` mirrors the slave; `s_byteenable` is 0011 throughout; `m0`, requesting meanwhile, is granted only after the `m1` completion plus one IDLE cycle.
- **Timeout.**
  - Stimulus: `TIMEOUT = 4`, slave `waitrequest` stuck high.
  - Required: master `waitrequest` drops in the 5th GNT cycle; `timeout_err = 1` and stays 1; the next request is granted normally.
- **Mid-transfer reset.** Assert reset during a GNT0 wait state. Outputs go to reset values before the next clock edge; after release, a pending `m1` request is granted within 1 cycle if `m0` is idle.

Source files
------------

// File: rtl/avalon_bus_arbiter.sv
// -----------------------------------------------------------------------------
// avalon_bus_arbiter
//   Lets two Avalon-MM masters share one slave. m0 is the CPU data port and m1
//   is a secondary master such as a loader or DMA. Grants are round-robin. A
//   grant is held for one complete transfer, and every transfer returns through
//   one IDLE cycle. A per-transfer watchdog aborts a transfer whose slave holds
//   waitrequest high for TIMEOUT cycles, and it sets a sticky error flag.
//
// Handshake: a master holds read/write, address, data and byteenable stable
//   while its waitrequest is 1. The cycle in which its request is high and its
//   waitrequest is 0 completes the transfer. The slave follows the same rule
//   on s_*.
//
// Ports
//   clk, reset          clock, asynchronous active-low reset
//   m0_* / m1_*         master-side request (address, read, write, writedata,
//                       byteenable) and response (waitrequest, readdata)
//   s_*                 slave-side request and response
//   grant               one-hot current owner (bit0 = m0, bit1 = m1), 0 = idle
//   timeout_err         sticky watchdog abort flag
//   dbg_state           FSM state (0 IDLE, 1 GNT0, 2 GNT1)
// -----------------------------------------------------------------------------
module avalon_bus_arbiter #(
   parameter int TIMEOUT = 1023
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [31:0] m0_address,
   input  logic        m0_read,
   input  logic        m0_write,
   input  logic [31:0] m0_writedata,
   input  logic [3:0]  m0_byteenable,
   output logic        m0_waitrequest,
   output logic [31:0] m0_readdata,
   input  logic [31:0] m1_address,
   input  logic        m1_read,
   input  logic        m1_write,
   input  logic [31:0] m1_writedata,
   input  logic [3:0]  m1_byteenable,
   output logic        m1_waitrequest,
   output logic [31:0] m1_readdata,
   output logic [31:0] s_address,
   output logic        s_read,
   output logic        s_write,
   output logic [31:0] s_writedata,
   output logic [3:0]  s_byteenable,
   input  logic        s_waitrequest,
   input  logic [31:0] s_readdata,
   output logic [1:0]  grant,
   output logic        timeout_err,
   output logic [1:0]  dbg_state
);

   localparam int CW = $clog2(TIMEOUT + 1);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      GNT0 = 2'd1,
      GNT1 = 2'd2
   } state_t;

   state_t        r_state;
   state_t        w_next;
   logic          r_last_grant;   // 0 = m0 was granted last, 1 = m1
   logic [CW-1:0] r_wd_cnt;
   logic          r_timeout_err;

   logic w_req0;
   logic w_req1;
   logic w_cur_req;
   logic w_wd_hit;
   logic w_done;

   assign w_req0 = m0_read | m0_write;
   assign w_req1 = m1_read | m1_write;

   assign w_cur_req = (r_state == GNT0) ? w_req0 :
                      (r_state == GNT1) ? w_req1 : 1'b0;

   // The watchdog fires only while the slave is still stalling. It releases
   // the master for that one cycle so the master always sees a completion.
   assign w_wd_hit = (r_wd_cnt == CW'(TIMEOUT)) && s_waitrequest;
   assign w_done   = w_cur_req && (!s_waitrequest || w_wd_hit);

   // Read data is broadcast. Only the owning master samples it.
   assign m0_readdata = s_readdata;
   assign m1_readdata = s_readdata;
   assign timeout_err = r_timeout_err;
   assign dbg_state   = r_state;

   always_comb begin
      w_next         = r_state;
      s_address      = 32'h0;
      s_read         = 1'b0;
      s_write        = 1'b0;
      s_writedata    = 32'h0;
      s_byteenable   = 4'h0;
      m0_waitrequest = 1'b1;
      m1_waitrequest = 1'b1;
      grant          = 2'b00;
      case (r_state)
         IDLE: begin
            if (w_req0 && w_req1) begin
               w_next = r_last_grant ? GNT0 : GNT1;
            end else if (w_req0) begin
               w_next = GNT0;
            end else if (w_req1) begin
               w_next = GNT1;
            end
         end
         GNT0: begin
            grant          = 2'b01;
            s_address      = m0_address;
            s_write        = m0_write;
            s_read         = m0_read & ~m0_write;   // write wins if both set
            s_writedata    = m0_writedata;
            s_byteenable   = m0_byteenable;
            m0_waitrequest = s_waitrequest & ~w_wd_hit;
            // A withdrawn request also ends the grant, without an error.
            if (!w_req0 || w_done) begin
               w_next = IDLE;
            end
         end
         GNT1: begin
            grant          = 2'b10;
            s_address      = m1_address;
            s_write        = m1_write;
            s_read         = m1_read & ~m1_write;
            s_writedata    = m1_writedata;
            s_byteenable   = m1_byteenable;
            m1_waitrequest = s_waitrequest & ~w_wd_hit;
            if (!w_req1 || w_done) begin
               w_next = IDLE;
            end
         end
         default: begin
            w_next = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_state       <= IDLE;
         r_last_grant  <= 1'b1;
         r_wd_cnt      <= '0;
         r_timeout_err <= 1'b0;
      end else begin
         r_state <= w_next;
         if (r_state == IDLE && w_next == GNT0) begin
            r_last_grant <= 1'b0;
         end else if (r_state == IDLE && w_next == GNT1) begin
            r_last_grant <= 1'b1;
         end
         // Every grant is entered from IDLE, so clearing in IDLE gives a
         // zero count in the first GNT cycle. The count saturates.
         if (r_state == IDLE) begin
            r_wd_cnt <= '0;
         end else if (s_waitrequest && (r_wd_cnt != CW'(TIMEOUT))) begin
            r_wd_cnt <= r_wd_cnt + CW'(1);
         end
         if (w_wd_hit && w_cur_req) begin
            r_timeout_err <= 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_avalon_bus_arbiter.sv
// -----------------------------------------------------------------------------
// tb_avalon_bus_arbiter
//   Directed bench for avalon_bus_arbiter (TIMEOUT = 4). The slave is a
//   256-word RAM with a programmable number of wait states and a stuck mode.
//   Stimulus tasks push each expected completion record into a per-master
//   queue. A negedge monitor pops and compares a record whenever a master
//   sees waitrequest low. Cycle-exact grant and waitrequest checks run inline.
// -----------------------------------------------------------------------------
module tb_avalon_bus_arbiter;

  localparam int TO = 4;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] m0_address, m1_address;
  logic        m0_read, m0_write, m1_read, m1_write;
  logic [31:0] m0_writedata, m1_writedata;
  logic [3:0]  m0_byteenable, m1_byteenable;
  logic        m0_waitrequest, m1_waitrequest;
  logic [31:0] m0_readdata, m1_readdata;
  logic [31:0] s_address;
  logic        s_read, s_write;
  logic [31:0] s_writedata;
  logic [3:0]  s_byteenable;
  logic        s_waitrequest;
  logic [31:0] s_readdata;
  logic [1:0]  grant;
  logic        timeout_err;
  logic [1:0]  dbg_state;

  int n_vec = 0;
  int n_err = 0;

  // record = {grant, s_write, s_byteenable, s_address, data}
  logic [70:0] exp_q0[$];
  logic [70:0] exp_q1[$];

  avalon_bus_arbiter #(.TIMEOUT(TO)) dut (
    .clk(clk), .reset(reset),
    .m0_address(m0_address), .m0_read(m0_read), .m0_write(m0_write),
    .m0_writedata(m0_writedata), .m0_byteenable(m0_byteenable),
    .m0_waitrequest(m0_waitrequest), .m0_readdata(m0_readdata),
    .m1_address(m1_address), .m1_read(m1_read), .m1_write(m1_write),
    .m1_writedata(m1_writedata), .m1_byteenable(m1_byteenable),
    .m1_waitrequest(m1_waitrequest), .m1_readdata(m1_readdata),
    .s_address(s_address), .s_read(s_read), .s_write(s_write),
    .s_writedata(s_writedata), .s_byteenable(s_byteenable),
    .s_waitrequest(s_waitrequest), .s_readdata(s_readdata),
    .grant(grant), .timeout_err(timeout_err), .dbg_state(dbg_state)
  );

  // ---------------- clock / global bound ----------------
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL global_time_limit: bench did not finish");
    $fatal(1);
  end

  // ---------------- slave model ----------------
  logic [31:0] mem [0:255];
  logic        preset_done = 1'b0;
  int          slave_waits = 0;
  logic        slave_stuck = 1'b0;
  logic [7:0]  wcnt;

  assign s_waitrequest = (s_read | s_write) && (slave_stuck || (int'(wcnt) < slave_waits));
  assign s_readdata    = mem[s_address[9:2]];

  always @(posedge clk) begin
    if (!preset_done) begin
      for (int i = 0; i < 256; i++) mem[i] <= 32'h0;
      mem[5]      <= 32'h00006900;   // byte address 0x15
      mem[64]     <= 32'hA5A50001;   // byte address 0x100
      preset_done <= 1'b1;
    end else if (s_write && !s_waitrequest) begin
      for (int b = 0; b < 4; b++)
        if (s_byteenable[b]) mem[s_address[9:2]][8*b +: 8] <= s_writedata[8*b +: 8];
    end
  end

  always @(posedge clk or negedge reset) begin
    if (!reset) wcnt <= 8'd0;
    else if ((s_read | s_write) && s_waitrequest) wcnt <= wcnt + 8'd1;
    else wcnt <= 8'd0;
  end

  // ---------------- helpers ----------------
  function automatic logic [70:0] rec(input logic [1:0] g, input logic wr,
                                      input logic [3:0] be, input logic [31:0] a,
                                      input logic [31:0] d);
    return {g, wr, be, a, d};
  endfunction

  task automatic chk(input string name, input logic [70:0] act, input logic [70:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input int id, input logic rd, input logic wr, input logic [31:0] a,
                       input logic [31:0] d, input logic [3:0] be);
    if (id == 0) begin
      m0_read = rd; m0_write = wr; m0_address = a; m0_writedata = d; m0_byteenable = be;
    end else begin
      m1_read = rd; m1_write = wr; m1_address = a; m1_writedata = d; m1_byteenable = be;
    end
  endtask

  // One complete transfer. Call it just after a rising edge.
  task automatic xfer(input int id, input logic wr, input logic [31:0] a, input logic [31:0] d,
                      input logic [3:0] be, input logic [31:0] exp_rd);
    logic [70:0] e;
    int n;
    e = rec((id == 0) ? 2'b01 : 2'b10, wr, be, a, wr ? d : exp_rd);
    if (id == 0) exp_q0.push_back(e);
    else exp_q1.push_back(e);
    drive(id, !wr, wr, a, d, be);
    n = 0;
    forever begin
      @(negedge clk);
      if (((id == 0) ? m0_waitrequest : m1_waitrequest) == 1'b0) break;
      n++;
      if (n >= 200) begin
        n_vec++;
        n_err++;
        $display("FAIL xfer_wait_bound: m%0d got no completion in %0d cycles, required one", id, n);
        break;
      end
    end
    @(posedge clk);
    #1;
    drive(id, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
  endtask

  // ---------------- monitor / scoreboard ----------------
  logic [70:0] act0, act1;

  always @(negedge clk) begin
    if (reset) begin
      if (!m0_waitrequest) begin
        act0 = rec(grant, s_write, s_byteenable, s_address, s_write ? s_writedata : m0_readdata);
        if (exp_q0.size() == 0) begin
          n_vec++; n_err++;
          $display("FAIL m0_unexpected_completion: got %h, required no completion", act0);
        end else begin
          chk("m0_xfer", act0, exp_q0.pop_front());
        end
      end
      if (!m1_waitrequest) begin
        act1 = rec(grant, s_write, s_byteenable, s_address, s_write ? s_writedata : m1_readdata);
        if (exp_q1.size() == 0) begin
          n_vec++; n_err++;
          $display("FAIL m1_unexpected_completion: got %h, required no completion", act1);
        end else begin
          chk("m1_xfer", act1, exp_q1.pop_front());
        end
      end
    end
  end

  // ---------------- directed tests ----------------
  initial begin
    reset = 1'b0;
    drive(0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
    drive(1, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);

    // Reset held with m0 requesting.
    drive(0, 1'b1, 1'b0, 32'h100, 32'h0, 4'hF);
    repeat (3) @(negedge clk);
    chk("rst_s_read", s_read, 1'b0);
    chk("rst_m0_wait", m0_waitrequest, 1'b1);
    chk("rst_m1_wait", m1_waitrequest, 1'b1);
    chk("rst_grant", grant, 2'b00);
    chk("rst_err", timeout_err, 1'b0);
    chk("rst_s_addr", s_address, 32'h0);
    chk("rst_state", dbg_state, 2'd0);
    exp_q0.push_back(rec(2'b01, 1'b0, 4'hF, 32'h100, 32'hA5A50001));
    #2 reset = 1'b1;
    tick();
    chk("rel_grant", grant, 2'b01);
    chk("rel_s_addr", s_address, 32'h100);
    tick();
    drive(0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);

    // Single zero-wait read of 0x15.
    tick();
    exp_q0.push_back(rec(2'b01, 1'b0, 4'hF, 32'h15, 32'h00006900));
    drive(0, 1'b1, 1'b0, 32'h15, 32'h0, 4'hF);
    @(negedge clk);
    chk("rd_c1_wait", m0_waitrequest, 1'b1);
    chk("rd_c1_grant", grant, 2'b00);
    @(negedge clk);
    chk("rd_c2_wait", m0_waitrequest, 1'b0);
    chk("rd_c2_data", m0_readdata, 32'h00006900);
    chk("rd_c2_grant", grant, 2'b01);
    @(posedge clk);
    #1 drive(0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
    @(negedge clk);
    chk("rd_c3_grant", grant, 2'b00);
    chk("rd_c3_wait", m0_waitrequest, 1'b1);

    // m1 write with 3 wait states; m0 requests meanwhile.
    slave_waits = 3;
    tick();
    fork
      xfer(1, 1'b1, 32'h200, 32'hDEADBEEF, 4'b0011, 32'h0);
      begin
        tick();
        xfer(0, 1'b0, 32'h15, 32'h0, 4'hF, 32'h00006900);
      end
      begin
        @(negedge clk);
        chk("ws_d1_grant", grant, 2'b00);
        for (int k = 0; k < 4; k++) begin
          @(negedge clk);
          chk("ws_grant", grant, 2'b10);
          chk("ws_m1_wait", m1_waitrequest, (k < 3) ? 1'b1 : 1'b0);
          chk("ws_mirror", m1_waitrequest, s_waitrequest);
          chk("ws_be", s_byteenable, 4'b0011);
          chk("ws_m0_wait", m0_waitrequest, 1'b1);
        end
        @(negedge clk);
        chk("ws_idle_gap", grant, 2'b00);
        @(negedge clk);
        chk("ws_m0_grant", grant, 2'b01);
      end
    join
    slave_waits = 0;
    chk("ws_mem", mem[128], 32'h0000BEEF);

    // A single m1 write, which makes m1 the last grant before contention.
    xfer(1, 1'b1, 32'h300, 32'h12345678, 4'hF, 32'h0);
    chk("wr_mem", mem[192], 32'h12345678);

    // Contention: both masters write 69 continuously.
    fork
      begin
        for (int i = 0; i < 3; i++) xfer(0, 1'b1, 32'h40 + 32'(4 * i), 32'd69, 4'hF, 32'h0);
      end
      begin
        for (int i = 0; i < 3; i++) xfer(1, 1'b1, 32'h80 + 32'(4 * i), 32'd69, 4'hF, 32'h0);
      end
      begin
        for (int c = 1; c <= 12; c++) begin
          @(negedge clk);
          chk("cont_grant", grant, (c % 4 == 2) ? 2'b01 : ((c % 4 == 0) ? 2'b10 : 2'b00));
        end
      end
    join
    chk("cont_mem0", mem[16], 32'd69);
    chk("cont_mem1", mem[34], 32'd69);

    // Watchdog: the slave is stuck, so the abort comes in the 5th GNT cycle.
    chk("to_err_before", timeout_err, 1'b0);
    slave_stuck = 1'b1;
    exp_q0.push_back(rec(2'b01, 1'b1, 4'hF, 32'h44, 32'h77));
    drive(0, 1'b0, 1'b1, 32'h44, 32'h77, 4'hF);
    @(negedge clk);
    chk("to_t1_grant", grant, 2'b00);
    for (int k = 1; k <= 5; k++) begin
      @(negedge clk);
      chk("to_m0_wait", m0_waitrequest, (k < 5) ? 1'b1 : 1'b0);
      chk("to_grant", grant, 2'b01);
      chk("to_err_pre", timeout_err, 1'b0);
    end
    @(posedge clk);
    #1;
    drive(0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
    slave_stuck = 1'b0;
    @(negedge clk);
    chk("to_err_set", timeout_err, 1'b1);
    chk("to_idle", grant, 2'b00);
    chk("to_mem_kept", mem[17], 32'd69);
    tick();
    xfer(1, 1'b0, 32'h15, 32'h0, 4'hF, 32'h00006900);
    chk("to_err_sticky", timeout_err, 1'b1);

    // Reset during a GNT0 wait state, with m1 pending afterwards.
    slave_waits = 3;
    drive(0, 1'b1, 1'b0, 32'h15, 32'h0, 4'hF);
    @(negedge clk);
    @(negedge clk);
    chk("mr_grant_before", grant, 2'b01);
    chk("mr_wait_before", m0_waitrequest, 1'b1);
    #2 reset = 1'b0;
    #1;
    chk("mr_grant", grant, 2'b00);
    chk("mr_s_read", s_read, 1'b0);
    chk("mr_s_addr", s_address, 32'h0);
    chk("mr_m0_wait", m0_waitrequest, 1'b1);
    chk("mr_state", dbg_state, 2'd0);
    chk("mr_err_clr", timeout_err, 1'b0);
    drive(0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
    drive(1, 1'b0, 1'b1, 32'h50, 32'h99, 4'hF);
    slave_waits = 0;
    exp_q1.push_back(rec(2'b10, 1'b1, 4'hF, 32'h50, 32'h99));
    @(posedge clk);
    @(negedge clk);
    #2 reset = 1'b1;
    tick();
    chk("mr_m1_grant", grant, 2'b10);
    tick();
    drive(1, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
    repeat (2) @(negedge clk);
    chk("mr_mem", mem[20], 32'h99);

    chk("q0_empty", exp_q0.size(), 0);
    chk("q1_empty", exp_q1.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
